// File: rtl/prog_sequencer.sv
// prog_sequencer: launches a queue of PIMP programs from a start-address
// table, times each run, and aborts the queue through a watchdog.
// Ports:
//   CLK, Reset (sync, active high)
//   cfg_we/cfg_idx/cfg_addr : table write (honoured in IDLE/DONE only)
//   go/num_progs            : start a queue of num_progs entries from 0
//   core_start/core_start_addr/core_halt : core launch handshake
//   busy/all_done/cur_prog  : run status
//   stat_valid/stat_idx/stat_cycles/stat_timeout : per-program result
//   err_timeout             : sticky watchdog flag
module prog_sequencer #(
  parameter int NUM_PROGS  = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF,
  parameter int START_HOLD = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_addr,
  input  logic             go,
  input  logic [IDX_W:0]   num_progs,
  output logic             core_start,
  output logic [7:0]       core_start_addr,
  input  logic             core_halt,
  output logic             busy,
  output logic             all_done,
  output logic [IDX_W-1:0] cur_prog,
  output logic             stat_valid,
  output logic [IDX_W-1:0] stat_idx,
  output logic [CNT_W-1:0] stat_cycles,
  output logic             stat_timeout,
  output logic             err_timeout
);

  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HW-1:0] LAST_HOLD = HW'(START_HOLD - 1);
  localparam logic [IDX_W:0] MAX_PROGS = (IDX_W+1)'(NUM_PROGS);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       tbl [NUM_PROGS];
  logic [IDX_W:0]   numProgsQ;
  logic [CNT_W-1:0] cnt;
  logic [HW-1:0]    holdCnt;

  logic [CNT_W-1:0] nextCnt;
  logic [IDX_W:0]   nextIdx;
  logic             moreProgs;
  logic             goOk;
  logic             cfgOpen;

  // Counter saturates so a huge TIMEOUT can never wrap past the compare.
  assign nextCnt   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign nextIdx   = {1'b0, cur_prog} + 1'b1;
  assign moreProgs = nextIdx < numProgsQ;
  assign goOk      = (num_progs != '0) && (num_progs <= MAX_PROGS);
  assign cfgOpen   = (state == IDLE) || (state == DONE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state           <= IDLE;
      for (int i = 0; i < NUM_PROGS; i++) tbl[i] <= 8'h00;
      numProgsQ       <= '0;
      cnt             <= '0;
      holdCnt         <= '0;
      core_start      <= 1'b0;
      core_start_addr <= 8'h00;
      busy            <= 1'b0;
      all_done        <= 1'b0;
      cur_prog        <= '0;
      stat_valid      <= 1'b0;
      stat_idx        <= '0;
      stat_cycles     <= '0;
      stat_timeout    <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (cfg_we && cfgOpen) tbl[cfg_idx] <= cfg_addr;

      case (state)
        IDLE, DONE: begin
          if (go) begin
            err_timeout <= 1'b0;
            numProgsQ   <= num_progs;
            if (goOk) begin
              cur_prog        <= '0;
              core_start_addr <= tbl[0];
              core_start      <= 1'b1;
              holdCnt         <= '0;
              cnt             <= '0;
              busy            <= 1'b1;
              all_done        <= 1'b0;
              state           <= LAUNCH;
            end else begin
              busy     <= 1'b0;
              all_done <= 1'b1;
              state    <= DONE;
            end
          end
        end

        LAUNCH: begin
          cnt <= '0;
          if (holdCnt == LAST_HOLD) begin
            core_start <= 1'b0;
            state      <= RUN;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end

        RUN: begin
          cnt <= nextCnt;
          if (core_halt) begin
            stat_valid   <= 1'b1;
            stat_idx     <= cur_prog;
            stat_cycles  <= nextCnt;
            stat_timeout <= 1'b0;
            if (moreProgs) begin
              cur_prog        <= nextIdx[IDX_W-1:0];
              core_start_addr <= tbl[nextIdx[IDX_W-1:0]];
              core_start      <= 1'b1;
              holdCnt         <= '0;
              state           <= LAUNCH;
            end else begin
              busy     <= 1'b0;
              all_done <= 1'b1;
              state    <= DONE;
            end
          end else if (nextCnt == TIMEOUT) begin
            stat_valid   <= 1'b1;
            stat_idx     <= cur_prog;
            stat_cycles  <= TIMEOUT;
            stat_timeout <= 1'b1;
            err_timeout  <= 1'b1;
            busy         <= 1'b0;
            all_done     <= 1'b1;
            state        <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller that sits in front of the PIMP core. It launches a queue of programs held in a small start-address table, one after another.
- For each program it drives the core's start and start_addr, then waits for the core's done/halt indication and measures the cycles it took.
- A watchdog aborts the queue if a program hangs. Per-program results are reported on a status strobe for the bench or a host.

Parameters:
- NUM_PROGS, 4, number of entries in the start-address table (power of 2, 2..16).
- IDX_W, 2, width of program index; equals log2(NUM_PROGS).
- CNT_W, 16, width of the cycle counter.
- TIMEOUT, 16'hFFFF, RUN cycles allowed per program before abort; legal range 1..2^CNT_W-1.
- START_HOLD, 2, cycles core_start is held high per launch; minimum 1.

Ports:
- CLK, in, 1, system clock; all logic on posedge.
- Reset, in, 1, synchronous active-high reset.
- cfg_we, in, 1, write strobe for the start-address table.
- cfg_idx, in, IDX_W, table entry to write.
- cfg_addr, in, 8, start address to store.
- go, in, 1, begin running the queue.
- num_progs, in, IDX_W+1, number of entries to run, starting at entry 0; sampled when go is accepted.
- core_start, out, 1, drives the core start input.
- core_start_addr, out, 8, drives the core start_addr input.
- core_halt, in, 1, core done output.
- busy, out, 1, high in LAUNCH or RUN.
- all_done, out, 1, high in DONE.
- cur_prog, out, IDX_W, index of the program currently running.
- stat_valid, out, 1, one-cycle result strobe.
- stat_idx, out, IDX_W, program index for the result.
- stat_cycles, out, CNT_W, RUN cycles consumed, including the halt cycle.
- stat_timeout, out, 1, result is a watchdog abort.
- err_timeout, out, 1, sticky error flag; cleared by an accepted go or by Reset.

Behaviour:
- Reset, sampled on a CLK edge, forces the following, including mid-run:
  - state goes to IDLE;
  - all table entries become 8'h00;
  - core_start, busy, all_done, stat_valid, stat_timeout and err_timeout become 0;
  - cur_prog, stat_idx, stat_cycles, core_start_addr and the counters become 0.
- Table writes:
  - cfg_we is honoured only in IDLE or DONE; in any other state it is ignored.
  - A write lands on the clock edge, so a go in the same cycle uses the old value.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE and DONE:
  - go is accepted; it clears err_timeout and latches num_progs.
  - If the latched num_progs is 0 or greater than NUM_PROGS, go goes straight to DONE with no launch and no stat strobe.
  - Otherwise cur_prog becomes 0 and state goes to LAUNCH.
  - go in LAUNCH or RUN is ignored.
- LAUNCH:
  - core_start is 1 for exactly START_HOLD consecutive cycles.
  - core_start_addr equals table[cur_prog] and stays stable through LAUNCH and RUN.
  - The cycle counter is cleared.
  - core_halt is ignored throughout LAUNCH.
  - After the last hold cycle, state goes to RUN.
- RUN:
  - core_start is 0.
  - The counter increments every cycle, saturating at all-ones.
  - If core_halt=1: pulse stat_valid with stat_idx=cur_prog, stat_cycles=incremented count, stat_timeout=0.
    - If cur_prog+1 < num_progs, increment cur_prog and go to LAUNCH.
    - Else go to DONE.
  - Else if the incremented count == TIMEOUT: pulse stat_valid with stat_cycles=TIMEOUT and stat_timeout=1, set err_timeout, skip the remaining programs, and go to DONE.
  - core_halt on the same cycle wins over timeout.
- DONE:
  - all_done=1.
  - cur_prog holds the last launched index.
  - State remains until go or Reset.
- Output timing:
  - core_start_addr reads 8'h00 in IDLE and holds its last value in DONE.
  - All outputs are registered.
  - stat fields other than stat_valid hold their last value between strobes.
  - The stat strobe is coincident with the state leaving RUN.

Test Plan:
- Reset, write table {8'h10, 8'h20, 8'h30}, num_progs=3, go. Bench core asserts halt after 5, 7 and 9 RUN cycles. Expect:
  - core_start high for 2 cycles per launch, with addresses 10, 20, 30;
  - stat strobes (0,5,0), (1,7,0), (2,9,0);
  - all_done thereafter and err_timeout=0.
- TIMEOUT=20 and the core never halts. Expect:
  - stat (0,20,1);
  - err_timeout=1 and DONE;
  - no second launch;
  - a fresh go clears err_timeout.
- core_halt asserted throughout LAUNCH and on the first RUN cycle. Expect:
  - LAUNCH is unaffected;
  - stat_cycles=1.
- Simultaneous events:
  - halt on the exact TIMEOUT cycle: expect stat_timeout=0 and the queue continues;
  - go while busy: ignored;
  - cfg_we in RUN: table is unchanged.
- Reset asserted in the middle of RUN of program 1. Expect:
  - next cycle IDLE;
  - core_start=0, busy=0, all_done=0, stat_valid=0, all table entries 8'h00.
- num_progs=0, and separately num_progs=5. Expect an immediate DONE the cycle after go, with no core_start and no stat_valid.
